// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps a combinational gate through all input vectors,
// captures its truth table and compares it with EXPECTED.
// Optional macro SWEEP_STOP_ON_FAIL_EN: stop at the first mismatching row
// and report its index on o_first_fail.
module gate_sweep_ctrl #(
  parameter int N_IN = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b0110
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [N_IN-1:0]      o_gate_in,
  input  logic                 i_gate_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [(1<<N_IN)-1:0] o_table_out
`ifdef SWEEP_STOP_ON_FAIL_EN
  ,
  output logic [N_IN-1:0]      o_first_fail
`endif
);

  localparam int NV = 1 << N_IN;
  localparam int IW = N_IN + 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] LAST = IW'(NV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_mis;
  logic [N_IN-1:0] r_gate_in;
  logic            r_pass;
  logic [NV-1:0]   r_table;

  logic [N_IN-1:0] w_idx_lo;
  logic            w_bit_bad;
  logic            w_mis;
  logic            w_last;
  logic            w_stop;

  assign w_idx_lo  = r_idx[N_IN-1:0];
  assign w_bit_bad = i_gate_out != EXPECTED[w_idx_lo];
  assign w_mis     = r_mis | w_bit_bad;
  assign w_last    = r_idx == LAST;

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign w_stop = w_last | w_bit_bad;
`else
  assign w_stop = w_last;
`endif

  assign o_gate_in   = r_gate_in;
  assign o_pass      = r_pass;
  assign o_table_out = r_table;
  assign o_busy      = r_state != S_IDLE;
  assign o_done      = r_state == S_DONE;

  // State register; reset aborts any sweep without a done pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (i_start) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == '0) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_stop ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Sweep datapath: vector index, settle counter, capture and verdict
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_mis     <= 1'b0;
      r_gate_in <= '0;
      r_pass    <= 1'b0;
      r_table   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_gate_in <= '0;
          if (i_start) begin
            r_idx   <= '0;
            r_cnt   <= RELOAD;
            r_mis   <= 1'b0;
            r_pass  <= 1'b0;
            r_table <= '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_SAMPLE: begin
          r_table[w_idx_lo] <= i_gate_out;
          r_mis             <= w_mis;
          if (w_stop) begin
            r_pass <= ~w_mis;
          end else begin
            r_idx     <= r_idx + 1'b1;
            r_gate_in <= w_idx_lo + 1'b1;
            r_cnt     <= RELOAD;
          end
        end
        S_DONE: begin
          r_gate_in <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_STOP_ON_FAIL_EN
  logic [N_IN-1:0] r_first_fail;

  assign o_first_fail = r_first_fail;

  // Index of the row that ended the sweep early
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_first_fail <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_first_fail <= '0;
    end else if (r_state == S_SAMPLE && w_bit_bad && !r_mis) begin
      r_first_fail <= w_idx_lo;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: table-driven, hand-written and random sweeps of
// gate_sweep_ctrl against a truth-table reference model.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic       i_gate_out;
  logic [1:0] o_gate_in;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [3:0] o_table_out;
`ifdef SWEEP_STOP_ON_FAIL_EN
  logic [1:0] o_first_fail;
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam logic [3:0] EXP = 4'b0110;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gate_sweep_ctrl #(
    .N_IN(2),
    .SETTLE_CYCLES(2),
    .EXPECTED(4'b0110)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .o_gate_in(o_gate_in),
    .i_gate_out(i_gate_out),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_pass(o_pass),
    .o_table_out(o_table_out)
`ifdef SWEEP_STOP_ON_FAIL_EN
    ,
    .o_first_fail(o_first_fail)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: row i of the table is the gate's value at vector i; each
  // row costs 3 cycles and DONE follows the last row sampled.
  task automatic ref_model(input logic [3:0] t, output logic [3:0] tab,
                           output bit pas, output int dc, output int ff);
    bit stopped;
    tab = '0;
    pas = 1'b1;
    ff = 0;
    dc = 4 * 3 + 1;
    stopped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stopped) begin
        tab[i] = t[i];
        if (t[i] != EXP[i]) begin
          pas = 1'b0;
          if (STOP) begin
            stopped = 1'b1;
            ff = i;
            dc = (i + 1) * 3 + 1;
          end
        end
      end
    end
  endtask

  task automatic run_sweep(input string nm, input logic [3:0] t,
                           input bit nz, input logic [3:0] x_tab,
                           input bit x_pass, input int x_dc,
                           input int x_ff);
    int dc;
    bit gi_bad;
    bit busy_bad;
    dc = 0;
    gi_bad = 1'b0;
    busy_bad = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int c = 1; c <= 40 && dc == 0; c++) begin
      if (nz && (c % 3) != 0) i_gate_out = 1'($urandom);
      else                    i_gate_out = t[o_gate_in];
      if (c < x_dc && o_gate_in !== 2'((c - 1) / 3)) gi_bad = 1'b1;
      if (o_busy !== 1'b1) busy_bad = 1'b1;
      if (o_done === 1'b1) begin
        dc = c;
        check({nm, " table"}, 32'(o_table_out), 32'(x_tab));
        check({nm, " pass"}, 32'(o_pass), 32'(x_pass));
`ifdef SWEEP_STOP_ON_FAIL_EN
        check({nm, " first_fail"}, 32'(o_first_fail), 32'(x_ff));
`endif
      end
      @(posedge clk);
      #1;
    end
    check({nm, " done_cycle"}, 32'(dc), 32'(x_dc));
    check({nm, " gate_in_seq_bad"}, 32'(gi_bad), 32'd0);
    check({nm, " busy_drop"}, 32'(busy_bad), 32'd0);
    check({nm, " idle busy"}, 32'(o_busy), 32'd0);
    check({nm, " idle done"}, 32'(o_done), 32'd0);
    check({nm, " idle gate_in"}, 32'(o_gate_in), 32'd0);
    check({nm, " held table"}, 32'(o_table_out), 32'(x_tab));
    check({nm, " held pass"}, 32'(o_pass), 32'(x_pass));
    if (x_ff < 0) $display("unused ff %0d", x_ff);
  endtask

  typedef struct {
    string      name;
    logic [3:0] tt;
    logic [3:0] tab_full;
    logic       pass;
    logic [3:0] tab_stop;
    int         ff;
    int         dc_stop;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0] rt;
    logic [3:0] rtab;
    bit rpass;
    int rdc;
    int rff;
    int dones[$];

    i_reset = 1'b1;
    i_start = 1'b0;
    i_gate_out = 1'b0;

    vecs[0] = '{"xor",    4'b0110, 4'b0110, 1'b1, 4'b0110, 0, 13};
    vecs[1] = '{"stuck0", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1, 7};
    vecs[2] = '{"and",    4'b1000, 4'b1000, 1'b0, 4'b0000, 1, 7};
    vecs[3] = '{"or",     4'b1110, 4'b1110, 1'b0, 4'b1110, 3, 13};
    vecs[4] = '{"stuck1", 4'b1111, 4'b1111, 1'b0, 4'b0001, 0, 4};
    vecs[5] = '{"nand",   4'b0111, 4'b0111, 1'b0, 4'b0001, 0, 4};

    repeat (3) @(posedge clk);
    #1;
    check("rst gate_in", 32'(o_gate_in), 32'd0);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    check("rst pass", 32'(o_pass), 32'd0);
    check("rst table", 32'(o_table_out), 32'd0);
`ifdef SWEEP_STOP_ON_FAIL_EN
    check("rst first_fail", 32'(o_first_fail), 32'd0);
`endif
    i_reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      if (STOP)
        run_sweep(vecs[v].name, vecs[v].tt, 1'b0, vecs[v].tab_stop,
                  vecs[v].pass, vecs[v].dc_stop, vecs[v].ff);
      else
        run_sweep(vecs[v].name, vecs[v].tt, 1'b0, vecs[v].tab_full,
                  vecs[v].pass, 13, 0);
    end

    // start pulses while busy and in DONE are dropped; IDLE one restarts
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 32; c++) begin
      i_start = (c == 4 || c == 13 || c == 14);
      i_gate_out = EXP[o_gate_in];
      if (o_done === 1'b1) dones.push_back(c);
      if (c == 15) begin
        check("restart table clr", 32'(o_table_out), 32'd0);
        check("restart pass clr", 32'(o_pass), 32'd0);
        check("restart busy", 32'(o_busy), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    check("restart done count", 32'(dones.size()), 32'd2);
    if (dones.size() == 2) begin
      check("restart done1", 32'(dones[0]), 32'd13);
      check("restart done2", 32'(dones[1]), 32'd27);
    end

    // reset mid-sweep
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      i_gate_out = 1'b1;
      if (c == 5) i_reset = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort busy", 32'(o_busy), 32'd0);
    check("abort gate_in", 32'(o_gate_in), 32'd0);
    check("abort table", 32'(o_table_out), 32'd0);
    check("abort done", 32'(o_done), 32'd0);
    i_reset = 1'b0;
    rdc = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_done === 1'b1) rdc++;
      @(posedge clk);
      #1;
    end
    check("abort no done", 32'(rdc), 32'd0);

    // random gates with glitchy output outside the sample cycles
    for (int r = 0; r < 20; r++) begin
      rt = 4'($urandom);
      ref_model(rt, rtab, rpass, rdc, rff);
      run_sweep($sformatf("rnd%0d", r), rt, 1'b1, rtab, rpass, rdc, rff);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
